vga_sync_decoder: RTL and testbench

- Receive side of the VGA timing interface: takes hsync/vsync from a video timing source and recovers horizontal/vertical position.
- Measures line and frame length, locks to the configured format, and reports the active-pixel window and recovered pixel coordinates.
- Used as an on-chip checker of the display timing path, and as the front end for any block that consumes a VGA-timed stream.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_sync_edge.sv | 23 ++
 rtl/vga_sync_decoder.sv | 163 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the sync-decoder lock state type.
// Used by both the timing generator and the receive-side decoder.
package vga_timing_pkg;

  localparam int DEF_H_SYNC_END  = 96;
  localparam int DEF_V_SYNC_END  = 2;
  localparam int DEF_H_START     = 144;
  localparam int DEF_V_START     = 35;
  localparam int DEF_WIDTH       = 640;
  localparam int DEF_HEIGHT      = 480;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_LOCK_FRAMES = 2;
  localparam int DEF_CNT_W       = 11;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and flags its leading (falling) edge.
// The history register only advances while en_i is high; the pulse is combinational.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic sync_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else if (en_i) begin
      prev_q <= sync_i;
    end
  end

  assign edge_o = en_i & prev_q & ~sync_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA position from hsync/vsync, locks to the configured format; outputs are
// registered, one clk after the sync sample. VGA_DEC_STATS_EN adds a saturating err_cnt.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC_END  = DEF_H_SYNC_END,
  parameter int V_SYNC_END  = DEF_V_SYNC_END,
  parameter int H_START     = DEF_H_START,
  parameter int V_START     = DEF_V_START,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             hsync,
  input  logic             vsync,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             active,
  output logic             locked,
  output logic             frame_start,
  output logic             sync_err,
`ifdef VGA_DEC_STATS_EN
  output logic [15:0]      err_cnt,
`endif
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines
);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  // Window never opens inside the sync pulse, even for an odd parameter set.
  localparam int H_LO = (H_START > H_SYNC_END) ? H_START : H_SYNC_END;
  localparam int V_LO = (V_START > V_SYNC_END) ? V_START : V_SYNC_END;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_TMO_C   = CNT_W'(2 * H_TOTAL);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_LO_C    = CNT_W'(H_LO);
  localparam logic [CNT_W-1:0] V_LO_C    = CNT_W'(V_LO);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + WIDTH);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + HEIGHT);

  sync_state_e     state_q;
  logic [GW-1:0]   good_q;
  logic            bad_q;
  logic [CNT_W-1:0] h_pos_q, v_pos_q;

  logic             h_edge, v_edge;
  logic [CNT_W-1:0] h_inc, v_inc, h_pos_d, v_pos_d, hx, vy;
  logic [GW-1:0]    good_inc;
  logic             line_bad, frame_bad, frame_ok, timeout;
  logic             lock_hit, lock_drop, locked_d, act_d;

  vga_sync_edge u_hs_edge (
    .clk    (clk),
    .rst_n  (RSTN),
    .en_i   (1'b1),
    .sync_i (hsync),
    .edge_o (h_edge)
  );

  vga_sync_edge u_vs_edge (
    .clk    (clk),
    .rst_n  (RSTN),
    .en_i   (h_edge),
    .sync_i (vsync),
    .edge_o (v_edge)
  );

  always_comb begin
    h_inc     = (h_pos_q == CNT_MAX) ? h_pos_q : h_pos_q + 1'b1;
    v_inc     = (v_pos_q == CNT_MAX) ? v_pos_q : v_pos_q + 1'b1;
    h_pos_d   = h_edge ? '0 : h_inc;
    v_pos_d   = v_edge ? '0 : (h_edge ? v_inc : v_pos_q);
    good_inc  = good_q + 1'b1;
    line_bad  = h_edge && (h_inc != H_TOTAL_C);
    frame_bad = v_edge && (v_inc != V_TOTAL_C);
    frame_ok  = !frame_bad && !line_bad && !bad_q;
    timeout   = !h_edge && (h_inc == H_TMO_C);
    lock_hit  = (state_q == VERIFY) && v_edge && frame_ok && (good_inc == GW'(LOCK_FRAMES));
    lock_drop = (state_q == LOCKED) && (line_bad || frame_bad);
    locked_d  = !timeout && (lock_hit || ((state_q == LOCKED) && !lock_drop));
    // Offsets stay at full counter width until the window test has passed.
    hx        = h_pos_d - H_START_C;
    vy        = v_pos_d - V_START_C;
    act_d     = locked_d && (h_pos_d >= H_LO_C) && (h_pos_d < H_END_C)
                         && (v_pos_d >= V_LO_C) && (v_pos_d < V_END_C);
  end

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      bad_q       <= 1'b0;
      h_pos_q     <= '0;
      v_pos_q     <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      active      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      h_pos_q     <= h_pos_d;
      v_pos_q     <= v_pos_d;
      frame_start <= v_edge;
      sync_err    <= timeout || lock_drop;
      active      <= act_d;
      pixel_x     <= act_d ? 10'(hx) : 10'd0;
      pixel_y     <= act_d ? 10'(vy) : 10'd0;
      if (h_edge) line_len <= h_inc;
      if (v_edge) frame_lines <= v_inc;
      if (v_edge) bad_q <= 1'b0;
      else if (line_bad) bad_q <= 1'b1;

      if (timeout) begin
        state_q <= SEARCH;
        good_q  <= '0;
      end else begin
        case (state_q)
          SEARCH: if (v_edge) begin
            state_q <= VERIFY;
            good_q  <= '0;
          end
          VERIFY: if (v_edge) begin
            if (frame_ok) begin
              good_q <= good_inc;
              if (lock_hit) state_q <= LOCKED;
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: if (lock_drop) begin
            state_q <= VERIFY;
            good_q  <= '0;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef VGA_DEC_STATS_EN
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      err_cnt <= '0;
    end else if ((timeout || lock_drop) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 40x20 format with a per-cycle scoreboard.
module tb_vga_sync_decoder;

  localparam int HT = 40, VT = 20, HSE = 4, VSE = 2, HS = 8, VS = 4;
  localparam int W = 24, H = 12, LF = 2, CW = 11;

  logic          clk = 1'b0;
  logic          RSTN, hsync, vsync;
  logic [9:0]    pixel_x, pixel_y;
  logic          active, locked, frame_start, sync_err;
  logic [CW-1:0] line_len, frame_lines;
`ifdef VGA_DEC_STATS_EN
  logic [15:0]   err_cnt;
`endif

  vga_sync_decoder #(
    .H_SYNC_END(HSE), .V_SYNC_END(VSE), .H_START(HS), .V_START(VS),
    .WIDTH(W), .HEIGHT(H), .H_TOTAL(HT), .V_TOTAL(VT),
    .LOCK_FRAMES(LF), .CNT_W(CW)
  ) dut (
    .clk(clk), .RSTN(RSTN), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err),
`ifdef VGA_DEC_STATS_EN
    .err_cnt(err_cnt),
`endif
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       act;
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, errors = 0;
  bit   chk_en = 1'b0, chk_lock = 1'b0;
  int   err_seen, err_v, err_h, err_len, act_cnt, max_px, max_py, tmo_i;
  logic err_locked, tmo_locked, tmo_active;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run_line(input int len, input int v);
    exp_t e;
    for (int h = 0; h < len; h++) begin
      hsync = (h < HSE) ? 1'b0 : 1'b1;
      vsync = (v < VSE) ? 1'b0 : 1'b1;
      if (chk_en) begin
        e.act = chk_lock && (h >= HS) && (h < HS + W) && (v >= VS) && (v < VS + H);
        e.px  = e.act ? 10'(h - HS) : 10'd0;
        e.py  = e.act ? 10'(v - VS) : 10'd0;
        e.fs  = (h == 0) && (v == 0);
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sync_err) begin
        if (err_seen == 0) begin
          err_v = v; err_h = h; err_len = int'(line_len); err_locked = locked;
        end
        err_seen++;
      end
      if (active) begin
        act_cnt++;
        if (int'(pixel_x) > max_px) max_px = int'(pixel_x);
        if (int'(pixel_y) > max_py) max_py = int'(pixel_y);
      end
      if (chk_en) begin
        e = sb_q.pop_front();
        chk("sb_active", active, e.act);
        chk("sb_pixel_x", pixel_x, e.px);
        chk("sb_pixel_y", pixel_y, e.py);
        chk("sb_frame_start", frame_start, e.fs);
      end
    end
  endtask

  task automatic run_frame(input int short_v, input int nlines);
    for (int v = 0; v < nlines; v++) run_line((v == short_v) ? HT - 1 : HT, v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_pixel_x"}, pixel_x, 0);
    chk({tag, "_pixel_y"}, pixel_y, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
`ifdef VGA_DEC_STATS_EN
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  initial begin
    RSTN = 1'b0; hsync = 1'b1; vsync = 1'b1;
    err_seen = 0; act_cnt = 0; max_px = 0; max_py = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    RSTN = 1'b1;

    // First V edge, then two clean frames to lock.
    run_frame(-1, VT);
    run_frame(-1, VT);
    chk("locked_before_lock", locked, 0);
    act_cnt = 0; max_px = 0; max_py = 0;
    chk_en = 1'b1; chk_lock = 1'b1;
    run_frame(-1, VT);
    chk_en = 1'b0;
    chk("locked_after_lock", locked, 1);
    chk("line_len", line_len, HT);
    chk("frame_lines", frame_lines, VT);
    chk("active_count", act_cnt, W * H);
    chk("max_pixel_x", max_px, W - 1);
    chk("max_pixel_y", max_py, H - 1);
    chk("no_err_clean", err_seen, 0);

    // One short line while locked.
    err_seen = 0;
    run_frame(6, VT);
    chk("short_err_count", err_seen, 1);
    chk("short_err_line", err_v, 7);
    chk("short_err_h", err_h, 0);
    chk("short_err_len", err_len, HT - 1);
    chk("short_err_unlock", err_locked, 0);
    run_frame(-1, VT);
    run_frame(-1, VT);
    chk("short_still_unlocked", locked, 0);
    chk_en = 1'b1;
    run_frame(-1, VT);
    chk_en = 1'b0;
    chk("short_relocked", locked, 1);
    chk("short_no_extra_err", err_seen, 1);

    // hsync stuck high: timeout at h_pos == 2*HT.
    err_seen = 0; tmo_i = -1; tmo_locked = 1'b1; tmo_active = 1'b1;
    for (int i = 0; i < 2 * HT + 10; i++) begin
      hsync = 1'b1; vsync = 1'b1;
      @(posedge clk);
      #1;
      if (sync_err) begin
        if (tmo_i < 0) begin
          tmo_i = i; tmo_locked = locked; tmo_active = active;
        end
        err_seen++;
      end
    end
    chk("timeout_cycle", tmo_i, HT);
    chk("timeout_pulses", err_seen, 1);
    chk("timeout_locked", tmo_locked, 0);
    chk("timeout_active", tmo_active, 0);

    // Relock, then reset in the middle of a frame.
    run_frame(-1, VT);
    run_frame(-1, VT);
    run_frame(-1, 10);
    run_line(20, 10);
    chk("pre_reset_locked", locked, 1);
    chk("pre_reset_active", active, 1);
    chk("pre_reset_pixel_x", pixel_x, 19 - HS);
    RSTN = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("midreset_hold");
    RSTN = 1'b1;
    run_frame(-1, VT);
    run_frame(-1, VT);
    chk("after_reset_unlocked", locked, 0);
    chk_en = 1'b1;
    run_frame(-1, VT);
    chk_en = 1'b0;
    chk("after_reset_relocked", locked, 1);

    // Three short lines in separate locked frames.
    err_seen = 0;
    for (int k = 0; k < 3; k++) begin
      run_frame(3, VT);
      run_frame(-1, VT);
      run_frame(-1, VT);
    end
    chk("stats_pulses", err_seen, 3);
`ifdef VGA_DEC_STATS_EN
    chk("stats_err_cnt", err_cnt, 3);
`endif
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
